// File: rtl/harris_pkg.sv
// Shared widths, datapath types and window helpers for the Harris corner response pipeline.
package harris_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned GRAD_W   = 11;
  localparam int unsigned PROD_W   = 21;
  localparam int unsigned SUM_W    = 25;
  localparam int unsigned RESP_W   = 60;
  localparam int unsigned LATENCY  = 6;
  localparam int unsigned WIN_DIM  = 6;
  localparam int unsigned N_CTR    = 16;
  localparam int unsigned IDX_W    = 9;
  localparam int unsigned THR_W    = 48;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned WIN_BITS = WIN_DIM * WIN_DIM * PIX_W;
  localparam int unsigned PATCH_W  = 9 * PIX_W;

  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic        [PROD_W-1:0] sq_t;
  typedef logic signed [PROD_W-1:0] xprod_t;
  typedef logic        [SUM_W-1:0]  usum_t;
  typedef logic signed [SUM_W-1:0]  ssum_t;
  typedef logic signed [RESP_W-1:0] resp_t;

  // Side-band payload that travels down the pipeline with each window.
  typedef struct packed {
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row;
    logic             last;
    logic [THR_W-1:0] thresh;
  } tag_t;

  // 3x3 patch centred on (r,c) of the 6x6 window, row-major.
  function automatic logic [PATCH_W-1:0] patch_at(input logic [WIN_BITS-1:0] w,
                                                  input int unsigned r,
                                                  input int unsigned c);
    logic [PATCH_W-1:0] p;
    p = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        p[(dr*3+dc)*PIX_W +: PIX_W] = w[((r+dr-1)*WIN_DIM + (c+dc-1))*PIX_W +: PIX_W];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sobel3x3.sv
// Registered 3x3 Sobel operator: horizontal and vertical gradients of one patch.
module sobel3x3
  import harris_pkg::*;
(
  input  logic               clk,
  input  logic [PATCH_W-1:0] patch_i,
  output grad_t              gx_o,
  output grad_t              gy_o
);

  function automatic logic [GRAD_W-1:0] px(input logic [PATCH_W-1:0] p,
                                           input int unsigned r,
                                           input int unsigned c);
    return GRAD_W'(p[(r*3+c)*PIX_W +: PIX_W]);
  endfunction

  logic [GRAD_W-1:0] l_sum, r_sum, t_sum, b_sum;

  // Weighted 1-2-1 column/row sums; each fits 10 bits, the difference 11 signed.
  always_comb begin
    l_sum = px(patch_i, 0, 0) + (px(patch_i, 1, 0) << 1) + px(patch_i, 2, 0);
    r_sum = px(patch_i, 0, 2) + (px(patch_i, 1, 2) << 1) + px(patch_i, 2, 2);
    t_sum = px(patch_i, 0, 0) + (px(patch_i, 0, 1) << 1) + px(patch_i, 0, 2);
    b_sum = px(patch_i, 2, 0) + (px(patch_i, 2, 1) << 1) + px(patch_i, 2, 2);
  end

  always_ff @(posedge clk) begin
    gx_o <= $signed(r_sum - l_sum);
    gy_o <= $signed(b_sum - t_sum);
  end

endmodule

// File: rtl/harris_response.sv
// Six-stage Harris corner response over a 6x6 window with col/row tracking.
// Optional per-frame corner counter enabled by defining HARRIS_CORNER_COUNT_EN.
module harris_response
  import harris_pkg::*;
#(
  parameter int unsigned WIN_COLS = 480,
  parameter int unsigned WIN_ROWS = 475,
  parameter int unsigned K_NUM    = 5,
  parameter int unsigned K_SHIFT  = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIN_BITS-1:0]      window,
  input  logic                     window_valid,
  input  logic [THR_W-1:0]         thresh,
  output logic signed [RESP_W-1:0] resp,
  output logic                     resp_valid,
  output logic                     corner,
  output logic [IDX_W-1:0]         col,
  output logic [IDX_W-1:0]         row,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         corner_count
);

  logic [IDX_W-1:0]    col_q, col_d, row_q, row_d;
  logic                last_col, last_row;
  logic [5:1]          v_q;
  tag_t                tag_q [1:5];
  tag_t                tag_d;
  logic [WIN_BITS-1:0] win1_q;

  // Window position tracker; advances only on accepted windows.
  always_comb begin
    last_col = (col_q == IDX_W'(WIN_COLS - 1));
    last_row = (row_q == IDX_W'(WIN_ROWS - 1));
    col_d    = last_col ? '0 : col_q + IDX_W'(1);
    row_d    = row_q;
    if (last_col) row_d = last_row ? '0 : row_q + IDX_W'(1);
    tag_d = '{col: col_q, row: row_q, last: last_col && last_row, thresh: thresh};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      v_q <= {v_q[4:1], window_valid};
      if (window_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (window_valid) begin
      win1_q   <= window;
      tag_q[1] <= tag_d;
    end
    for (int unsigned s = 2; s <= 5; s++) tag_q[s] <= tag_q[s-1];
  end

  grad_t gx [N_CTR];
  grad_t gy [N_CTR];

  for (genvar gi = 0; gi < N_CTR; gi++) begin : g_sobel
    localparam int unsigned CR = gi / 4 + 1;
    localparam int unsigned CC = gi % 4 + 1;
    sobel3x3 u_sobel (
      .clk     (clk),
      .patch_i (patch_at(win1_q, CR, CC)),
      .gx_o    (gx[gi]),
      .gy_o    (gy[gi])
    );
  end

  sq_t    gxx_q [N_CTR];
  sq_t    gyy_q [N_CTR];
  xprod_t gxy_q [N_CTR];

  // Magnitudes stay below 2^20, so 21-bit operands give exact products.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CTR; i++) begin
      gxx_q[i] <= PROD_W'(gx[i]) * PROD_W'(gx[i]);
      gyy_q[i] <= PROD_W'(gy[i]) * PROD_W'(gy[i]);
      gxy_q[i] <= PROD_W'(gx[i]) * PROD_W'(gy[i]);
    end
  end

  usum_t sxx_d, syy_d, sxx_q, syy_q;
  ssum_t sxy_d, sxy_q;

  always_comb begin
    sxx_d = '0;
    syy_d = '0;
    sxy_d = '0;
    for (int unsigned i = 0; i < N_CTR; i++) begin
      sxx_d = sxx_d + SUM_W'(gxx_q[i]);
      syy_d = syy_d + SUM_W'(gyy_q[i]);
      sxy_d = sxy_d + SUM_W'(gxy_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    sxx_q <= sxx_d;
    syy_q <= syy_d;
    sxy_q <= sxy_d;
  end

  resp_t             sxx_e, syy_e, sxy_e, det_d, det_q;
  logic [RESP_W-1:0] tr_d, tr_q;

  always_comb begin
    sxx_e = RESP_W'(sxx_q);
    syy_e = RESP_W'(syy_q);
    sxy_e = RESP_W'(sxy_q);
    det_d = sxx_e * syy_e - sxy_e * sxy_e;
    tr_d  = RESP_W'(sxx_q) + RESP_W'(syy_q);
  end

  always_ff @(posedge clk) begin
    det_q <= det_d;
    tr_q  <= tr_d;
  end

  logic [RESP_W-1:0] ktr2;
  resp_t             resp_d;
  logic              corner_d;

  // k*tr^2 is non-negative, so a logical shift implements the k scaling.
  always_comb begin
    ktr2     = RESP_W'(K_NUM) * tr_q * tr_q;
    resp_d   = det_q - $signed(ktr2 >> K_SHIFT);
    corner_d = v_q[5] && (resp_d > $signed(RESP_W'(tag_q[5].thresh)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp       <= '0;
      corner     <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      resp_valid <= v_q[5];
      resp       <= resp_d;
      corner     <= corner_d;
      frame_done <= v_q[5] && tag_q[5].last;
      col        <= tag_q[5].col;
      row        <= tag_q[5].row;
    end
  end

`ifdef HARRIS_CORNER_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_inc;

  // Saturating count that includes the frame's final result when it is loaded.
  always_comb begin
    cnt_inc = cnt_q;
    if (corner && (cnt_q != {CNT_W{1'b1}})) cnt_inc = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      corner_count <= '0;
    end else if (frame_done) begin
      cnt_q        <= '0;
      corner_count <= cnt_inc;
    end else begin
      cnt_q <= cnt_inc;
    end
  end
`else
  assign corner_count = '0;
`endif

endmodule
